// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types for the rv32 core, load/store unit subset.
//   ls_funct3_e    RV32I load/store width and sign code (instruction funct3 field)
//   lsu_state_e    load/store unit control state
//   ls_funct3_legal  funct3 legality for a load (we=0) or a store (we=1)
package rv32_pkg;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    localparam logic [3:0] BE_ALL = 4'b1111;

    // Stores only have signed-width codes; loads additionally allow BU/HU.
    function automatic logic ls_funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            ok = (funct3 <= 3'b010);
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                default:                                ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: combinational byte-lane logic for the load/store unit.
//   we, funct3, off   operation kind, width code and address low bits
//   wdata             raw store data (rs2)
//   rdata             raw bus read word
//   illegal           funct3 not valid for this direction
//   misaligned        alignment fault (only with RV32_LSU_MISALIGN_CHECK_EN)
//   be                bus byte enables
//   wdata_lane        store data replicated onto every lane
//   rdata_ext         extracted and sign/zero-extended load result
// Optional feature macro: RV32_LSU_MISALIGN_CHECK_EN.
module lsu_data_align
    import rv32_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    ls_funct3_e  f3_s;
    logic [1:0]  lane_s;
    logic [31:0] shifted_s;

    assign f3_s    = ls_funct3_e'(funct3);
    assign illegal = ~ls_funct3_legal(we, funct3);

    // Effective lane: halfwords snap to the even half, words always lane 0.
    always_comb begin
        lane_s = 2'b00;
        case (f3_s)
            LS_B, LS_BU: lane_s = off;
            LS_H, LS_HU: lane_s = {off[1], 1'b0};
            default:     lane_s = 2'b00;
        endcase
    end

`ifdef RV32_LSU_MISALIGN_CHECK_EN
    // Alignment fault for halfword and word accesses.
    always_comb begin
        misaligned = 1'b0;
        case (f3_s)
            LS_H, LS_HU: misaligned = off[0];
            LS_W:        misaligned = (off != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Byte enables: stores mark only their lanes, loads always read the full word.
    always_comb begin
        be = BE_ALL;
        if (we) begin
            case (f3_s)
                LS_B:    be = 4'b0001 << lane_s;
                LS_H:    be = 4'b0011 << lane_s;
                default: be = BE_ALL;
            endcase
        end else begin
            be = BE_ALL;
        end
    end

    // Replication lets the byte enables alone pick the destination lane.
    always_comb begin
        wdata_lane = wdata;
        case (f3_s)
            LS_B:    wdata_lane = {4{wdata[7:0]}};
            LS_H:    wdata_lane = {2{wdata[15:0]}};
            default: wdata_lane = wdata;
        endcase
    end

    assign shifted_s = rdata >> {lane_s, 3'b000};

    // Load extraction from the selected lane, then extension.
    always_comb begin
        rdata_ext = 32'h0000_0000;
        case (f3_s)
            LS_B:    rdata_ext = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LS_BU:   rdata_ext = {24'h00_0000, shifted_s[7:0]};
            LS_H:    rdata_ext = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LS_HU:   rdata_ext = {16'h0000, shifted_s[15:0]};
            LS_W:    rdata_ext = shifted_s;
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: rv32 load/store unit. Takes the ALU result as effective address and
// runs one req/gnt/rvalid data-bus transaction per operation.
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i, we_i, funct3_i   operation start, store/load, width/sign code
//   addr_i, wdata_i         effective address, store data
//   busy_o, done_o, err_o   in-flight flag, completion pulse, error (with done_o)
//   rdata_o                 extended load result (held until next completion)
//   data_*                  data bus master port (registered outputs)
// Optional feature macro: RV32_LSU_MISALIGN_CHECK_EN (misaligned access -> error).
module lsu
    import rv32_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    lsu_state_e  state_r;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;

    logic        al_we_s;
    logic [2:0]  al_funct3_s;
    logic [1:0]  al_off_s;
    logic        illegal_s;
    logic        misaligned_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_lane_s;
    logic [31:0] rdata_ext_s;

    // In IDLE the aligner sees the incoming request; afterwards the captured op.
    always_comb begin
        al_we_s     = we_r;
        al_funct3_s = funct3_r;
        al_off_s    = off_r;
        if (state_r == IDLE) begin
            al_we_s     = we_i;
            al_funct3_s = funct3_i;
            al_off_s    = addr_i[1:0];
        end else begin
            al_we_s     = we_r;
            al_funct3_s = funct3_r;
            al_off_s    = off_r;
        end
    end

    lsu_data_align u_align (
        .we         (al_we_s),
        .funct3     (al_funct3_s),
        .off        (al_off_s),
        .wdata      (wdata_i),
        .rdata      (data_rdata_i),
        .illegal    (illegal_s),
        .misaligned (misaligned_s),
        .be         (be_s),
        .wdata_lane (wdata_lane_s),
        .rdata_ext  (rdata_ext_s)
    );

    // Control FSM with all outputs registered; bus fields load only on acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            we_r         <= 1'b0;
            funct3_r     <= 3'b000;
            off_r        <= 2'b00;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            rdata_o      <= 32'h0000_0000;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= 32'h0000_0000;
            data_wdata_o <= 32'h0000_0000;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_i) begin
                        we_r     <= we_i;
                        funct3_r <= funct3_i;
                        off_r    <= addr_i[1:0];
                        busy_o   <= 1'b1;
                        if (illegal_s || misaligned_s) begin
                            // Faulting op never touches the bus.
                            state_r <= DONE;
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= 32'h0000_0000;
                        end else begin
                            state_r      <= REQ;
                            data_req_o   <= 1'b1;
                            data_we_o    <= we_i;
                            data_be_o    <= be_s;
                            data_addr_o  <= {addr_i[31:2], 2'b00};
                            data_wdata_o <= wdata_lane_s;
                        end
                    end
                end
                REQ: begin
                    // rvalid seen here is a protocol violation and is ignored.
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state_r    <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_rvalid_i) begin
                        state_r <= DONE;
                        done_o  <= 1'b1;
                        rdata_o <= we_r ? 32'h0000_0000 : rdata_ext_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    busy_o     <= 1'b0;
                    data_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i, we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

    lsu dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .rdata_o(rdata_o), .data_req_o(data_req_o),
        .data_gnt_i(data_gnt_i), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit m_illegal(input bit we, input logic [2:0] f3);
        if (we) return (f3 > 3'd2);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit e;
        e = m_illegal(we, f3);
`ifdef RV32_LSU_MISALIGN_CHECK_EN
        if ((a % m_size(f3)) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int s;
        s = m_size(f3);
        if (s == 1) return a % 4;
        if (s == 2) return ((a % 4) / 2) * 2;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] b;
        int o, s;
        if (!we) return 4'hF;
        o = m_off(f3, a);
        s = m_size(f3);
        b = 4'h0;
        for (int k = 0; k < 4; k++) if (k >= o && k < o + s) b[k] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int s;
        s = m_size(f3);
        r = 32'h0;
        for (int k = 0; k < 4; k++) r = r | (((wd >> (8 * (k % s))) & 32'hFF) << (8 * k));
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] v;
        int o, s;
        o = m_off(f3, a);
        s = m_size(f3);
        v = 32'h0;
        for (int i = 0; i < s; i++) v = v | (((word >> (8 * (o + i))) & 32'hFF) << (8 * i));
        if (!f3[2] && s < 4 && v[8 * s - 1]) v = v | (32'hFFFF_FFFF << (8 * s));
        return v;
    endfunction

    // ---------------- monitor: pops an expectation at every completion ----------------
    always @(negedge clk) begin
        if (!rst_i && done_o) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done_o=1 expected no completion (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("err_o", {31'd0, err_o}, {31'd0, mon_e.err});
                chk("rdata_o", rdata_o, mon_e.rdata);
                chk("done_latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // ---------------- driver + bus responder ----------------
    task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input int rdl,
                         input logic [31:0] rd, input bit junk);
        exp_t e;
        bit   err;
        err = m_err(we, f3, a);
        @(negedge clk);
        chk("busy_at_issue", {31'd0, busy_o}, 32'd0);
        e.err   = err;
        e.rdata = (err || we) ? 32'h0 : m_load(f3, a, rd);
        e.cyc   = cyc + (err ? 1 : 3 + gd + rdl);
        sb_q.push_back(e);
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        @(negedge clk);
        req_i = 1'b0;
        if (err) begin
            chk("err_no_bus_req", {31'd0, data_req_o}, 32'd0);
        end else begin
            for (int g = 0; g <= gd; g++) begin
                chk("bus_req", {31'd0, data_req_o}, 32'd1);
                chk("bus_addr", data_addr_o, a & 32'hFFFF_FFFC);
                chk("bus_we", {31'd0, data_we_o}, {31'd0, we});
                chk("bus_be", {28'd0, data_be_o}, {28'd0, m_be(we, f3, a)});
                if (we) chk("bus_wdata", data_wdata_o, m_wdata(f3, wd));
                if (junk && g == 0 && gd > 0) begin
                    req_i = 1'b1; we_i = ~we; funct3_i = 3'b010; addr_i = $urandom;
                end
                if (g == gd) data_gnt_i = 1'b1;
                @(negedge clk);
                req_i = 1'b0;
                data_gnt_i = 1'b0;
            end
            chk("req_drop_after_gnt", {31'd0, data_req_o}, 32'd0);
            for (int r = 0; r < rdl; r++) @(negedge clk);
            data_rvalid_i = 1'b1;
            data_rdata_i  = rd;
            @(negedge clk);
            data_rvalid_i = 1'b0;
            data_rdata_i  = $urandom;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
        chk({tag, "_rdata"}, rdata_o, 32'd0);
        chk({tag, "_req"}, {31'd0, data_req_o}, 32'd0);
        chk({tag, "_we"}, {31'd0, data_we_o}, 32'd0);
        chk({tag, "_be"}, {28'd0, data_be_o}, 32'd0);
        chk({tag, "_addr"}, data_addr_o, 32'd0);
        chk({tag, "_wdata"}, data_wdata_o, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h0;
        wdata_i = 32'h0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_i = 1'b0;

        // directed cases
        do_op(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0); // LW
        do_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_FFFF, 1'b0); // LB
        do_op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_FFFF, 1'b0); // LBU
        do_op(1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 0, 32'h8001_0000, 1'b0); // LHU
        do_op(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 0, 0, 32'h0, 1'b0); // SB
        do_op(1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 0, 0, 32'h0, 1'b0); // SH
        do_op(1'b0, 3'b010, 32'h0000_0400, 32'h0, 4, 1, 32'h1357_9BDF, 1'b1); // slow bus
        do_op(1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0); // misaligned LW
        do_op(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 1'b0);         // illegal load
        do_op(1'b1, 3'b100, 32'h0000_0100, 32'h5, 0, 0, 32'h0, 1'b0);         // illegal store

        // reset while waiting for rvalid, then a stray late response
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0300;
        @(negedge clk);
        req_i = 1'b0; data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0; rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk_all_zero("rst_in_wait");
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_2222;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_rvalid_no_done", {31'd0, done_o}, 32'd0);
            @(negedge clk);
        end

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                  1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
